// File: rtl/threshold_peak_mc_pkg.sv
// Shared types and helpers for the multi-channel threshold/peak detector.
// Holds the channel state encoding, default widths and width helpers.
package threshold_pkg;

    localparam int DW_DEF = 32;
    localparam int TW_DEF = 32;
    localparam int CW_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WIN  = 2'd1,
        ST_PEND = 2'd2
    } ch_state_e;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Channel-index width never collapses to zero, even for a single channel.
    function automatic int ch_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/threshold_peak_mc_if.sv
// Event output port of threshold_peak_mc: registered valid/ack handshake.
// Payload stays stable while evt_valid is high and evt_ack is low.
interface threshold_peak_mc_if
    import threshold_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int DW   = DW_DEF,
    parameter int TW   = TW_DEF
);
    localparam int CHW = ch_w(N_CH);

    logic           evt_valid;
    logic           evt_ack;
    logic [CHW-1:0] evt_ch;
    logic [DW-1:0]  evt_peak;
    logic [TW-1:0]  evt_time;

    modport master (
        output evt_valid,
        output evt_ch,
        output evt_peak,
        output evt_time,
        input  evt_ack
    );

    modport slave (
        input  evt_valid,
        input  evt_ch,
        input  evt_peak,
        input  evt_time,
        output evt_ack
    );

endinterface

// File: rtl/threshold_channel.sv
// One channel: IDLE/WIN/PEND window FSM with peak/timestamp capture and quiet-count hysteresis.
// Optional forced close after MAX_WIN window samples under THRESHOLD_MAXWIN_EN; PEND holds until acked.
module threshold_channel
    import threshold_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int TW = TW_DEF,
    parameter int CW = CW_DEF
`ifdef THRESHOLD_MAXWIN_EN
    ,
    parameter int MAX_WIN = 65535
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] sample_i,
    input  logic          sample_vld_i,
    input  logic [DW-1:0] high_i,
    input  logic [DW-1:0] low_i,
    input  logic [CW-1:0] hold_i,
    input  logic [TW-1:0] timer_i,
    input  logic          grant_ack_i,
    output logic          pend_o,
    output logic          drop_o,
    output logic [DW-1:0] peak_o,
    output logic [TW-1:0] time_o
);

    ch_state_e     state_q;
    logic [DW-1:0] peak_q;
    logic [TW-1:0] time_q;
    logic [CW-1:0] quiet_q;
    logic [CW-1:0] quiet_inc;
    logic [CW-1:0] hold_eff;
    logic          above;
    logic          below;

    assign above     = sample_i > high_i;
    assign below     = sample_i < low_i;
    assign hold_eff  = (hold_i == '0) ? CW'(1) : hold_i;
    assign quiet_inc = (&quiet_q) ? quiet_q : quiet_q + CW'(1);

`ifdef THRESHOLD_MAXWIN_EN
    localparam int WW = clog2(MAX_WIN + 1);
    logic [WW-1:0] win_q;
    logic [WW-1:0] win_inc;
    assign win_inc = win_q + WW'(1);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            peak_q  <= '0;
            time_q  <= '0;
            quiet_q <= '0;
`ifdef THRESHOLD_MAXWIN_EN
            win_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sample_vld_i && above) begin
                        peak_q  <= sample_i;
                        time_q  <= timer_i;
                        quiet_q <= '0;
`ifdef THRESHOLD_MAXWIN_EN
                        win_q   <= '0;
`endif
                        state_q <= ST_WIN;
                    end
                end
                ST_WIN: begin
                    if (sample_vld_i) begin
                        // Strict > on the peak keeps the earliest timestamp on ties.
                        if (above) begin
                            quiet_q <= '0;
                            if (sample_i > peak_q) begin
                                peak_q <= sample_i;
                                time_q <= timer_i;
                            end
                        end else if (below) begin
                            quiet_q <= quiet_inc;
                            if (quiet_inc >= hold_eff) begin
                                state_q <= ST_PEND;
                            end
                        end
`ifdef THRESHOLD_MAXWIN_EN
                        win_q <= win_inc;
                        if (32'(win_inc) >= MAX_WIN) begin
                            state_q <= ST_PEND;
                        end
`endif
                    end
                end
                ST_PEND: begin
                    if (grant_ack_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pend_o = (state_q == ST_PEND);
    // A crossing that arrives while the previous event is still queued is lost.
    assign drop_o = (state_q == ST_PEND) && sample_vld_i && above;
    assign peak_o = peak_q;
    assign time_o = time_q;

endmodule

// File: rtl/threshold_peak_mc.sv
// N_CH threshold/peak detectors sharing a sample timer; events leave round-robin on a registered valid/ack port.
// Close-to-valid latency 2 cycles, one bubble after each ack; optional THRESHOLD_MAXWIN_EN forces long windows closed.
module threshold_peak_mc
    import threshold_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int DW   = DW_DEF,
    parameter int TW   = TW_DEF,
    parameter int CW   = CW_DEF
`ifdef THRESHOLD_MAXWIN_EN
    ,
    parameter int MAX_WIN = 65535
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH*DW-1:0]   data,
    input  logic                 data_valid,
    input  logic [DW-1:0]        HIGH,
    input  logic [DW-1:0]        LOW,
    input  logic [CW-1:0]        HOLD,
    threshold_peak_mc_if.master  evt,
    output logic [N_CH-1:0]      ovf,
    input  logic                 ovf_clr
);

    localparam int CHW = ch_w(N_CH);

    logic [TW-1:0]   timer_q;
    logic [N_CH-1:0] pend_vec;
    logic [N_CH-1:0] drop_vec;
    logic [N_CH-1:0] ack_vec;
    logic [DW-1:0]   peak_arr [N_CH];
    logic [TW-1:0]   time_arr [N_CH];

    logic            evt_vld_q,  evt_vld_d;
    logic [CHW-1:0]  evt_ch_q,   evt_ch_d;
    logic [DW-1:0]   evt_peak_q, evt_peak_d;
    logic [TW-1:0]   evt_time_q, evt_time_d;
    logic [CHW-1:0]  last_q,     last_d;
    logic [N_CH-1:0] ovf_q,      ovf_d;

    logic            sel_vld;
    logic [CHW-1:0]  sel_ch;
    logic [CHW-1:0]  cand;
    int              arb_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q <= '0;
        end else if (data_valid) begin
            timer_q <= timer_q + TW'(1);
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign ack_vec[k] = evt_vld_q && evt.evt_ack && (evt_ch_q == CHW'(k));

        threshold_channel #(
            .DW (DW),
            .TW (TW),
            .CW (CW)
`ifdef THRESHOLD_MAXWIN_EN
            ,
            .MAX_WIN (MAX_WIN)
`endif
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .sample_i     (data[k*DW +: DW]),
            .sample_vld_i (data_valid),
            .high_i       (HIGH),
            .low_i        (LOW),
            .hold_i       (HOLD),
            .timer_i      (timer_q),
            .grant_ack_i  (ack_vec[k]),
            .pend_o       (pend_vec[k]),
            .drop_o       (drop_vec[k]),
            .peak_o       (peak_arr[k]),
            .time_o       (time_arr[k])
        );
    end

    // Round-robin: first pending channel at or after last grant + 1, wrapping.
    always_comb begin
        sel_vld = 1'b0;
        sel_ch  = '0;
        cand    = '0;
        arb_idx = 0;
        for (int i = 0; i < N_CH; i++) begin
            arb_idx = (int'(last_q) + 1 + i) % N_CH;
            cand    = CHW'(arb_idx);
            if (!sel_vld && pend_vec[cand]) begin
                sel_vld = 1'b1;
                sel_ch  = cand;
            end
        end
    end

    always_comb begin
        evt_vld_d  = evt_vld_q;
        evt_ch_d   = evt_ch_q;
        evt_peak_d = evt_peak_q;
        evt_time_d = evt_time_q;
        last_d     = last_q;
        if (evt_vld_q) begin
            if (evt.evt_ack) begin
                evt_vld_d = 1'b0;
            end
        end else if (sel_vld) begin
            evt_vld_d  = 1'b1;
            evt_ch_d   = sel_ch;
            evt_peak_d = peak_arr[sel_ch];
            evt_time_d = time_arr[sel_ch];
            last_d     = sel_ch;
        end
    end

    // A new drop in the same cycle as a clear leaves the bit set.
    always_comb begin
        ovf_d = ovf_clr ? '0 : ovf_q;
        ovf_d = ovf_d | drop_vec;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_vld_q  <= 1'b0;
            evt_ch_q   <= '0;
            evt_peak_q <= '0;
            evt_time_q <= '0;
            last_q     <= CHW'(N_CH - 1);
            ovf_q      <= '0;
        end else begin
            evt_vld_q  <= evt_vld_d;
            evt_ch_q   <= evt_ch_d;
            evt_peak_q <= evt_peak_d;
            evt_time_q <= evt_time_d;
            last_q     <= last_d;
            ovf_q      <= ovf_d;
        end
    end

    assign evt.evt_valid = evt_vld_q;
    assign evt.evt_ch    = evt_ch_q;
    assign evt.evt_peak  = evt_peak_q;
    assign evt.evt_time  = evt_time_q;
    assign ovf           = ovf_q;

endmodule

// File: tb/tb_threshold_peak_mc.sv
// Directed bench for threshold_peak_mc: peak capture, hysteresis, round-robin, overflow, reset, long windows.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_threshold_peak_mc;
    localparam int N_CH = 4;
    localparam int DW   = 16;
    localparam int TW   = 16;
    localparam int CW   = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [N_CH*DW-1:0]   data = '0;
    logic                 data_valid = 1'b0;
    logic [DW-1:0]        high_thr = '0;
    logic [DW-1:0]        low_thr = '0;
    logic [CW-1:0]        hold_cnt = '0;
    logic [N_CH-1:0]      ovf;
    logic                 ovf_clr = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    threshold_peak_mc_if #(.N_CH(N_CH), .DW(DW), .TW(TW)) evt_if ();

    threshold_peak_mc #(
        .N_CH (N_CH),
        .DW   (DW),
        .TW   (TW),
        .CW   (CW)
`ifdef THRESHOLD_MAXWIN_EN
        ,
        .MAX_WIN (8)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .data_valid (data_valid),
        .HIGH       (high_thr),
        .LOW        (low_thr),
        .HOLD       (hold_cnt),
        .evt        (evt_if),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic [15:0] c0, input logic [15:0] c1,
                                       input logic [15:0] c2, input logic [15:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic smp(input logic [63:0] d);
        data       = d;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        data       = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack1();
        evt_if.evt_ack = 1'b1;
        @(posedge clk);
        #1;
        evt_if.evt_ack = 1'b0;
    endtask

    task automatic chk_evt(input string tag, input int ch, input int peak, input int tm);
        chk({tag, "_vld"},  64'(evt_if.evt_valid), 64'd1);
        chk({tag, "_ch"},   64'(evt_if.evt_ch),    64'(ch));
        chk({tag, "_peak"}, 64'(evt_if.evt_peak),  64'(peak));
        chk({tag, "_time"}, 64'(evt_if.evt_time),  64'(tm));
    endtask

    initial begin
        evt_if.evt_ack = 1'b0;
        idle(3);
        chk("rst_vld",  64'(evt_if.evt_valid), 64'd0);
        chk("rst_ch",   64'(evt_if.evt_ch),    64'd0);
        chk("rst_peak", 64'(evt_if.evt_peak),  64'd0);
        chk("rst_time", 64'(evt_if.evt_time),  64'd0);
        chk("rst_ovf",  64'(ovf),              64'd0);
        rst      = 1'b1;
        high_thr = 16'd100;
        low_thr  = 16'd50;
        hold_cnt = 8'd3;
        idle(1);

        // Single channel peak, samples at timer 0..7.
        smp(pk(0, 0, 0, 0));
        smp(pk(0, 120, 0, 0));
        smp(pk(0, 200, 0, 0));
        smp(pk(0, 150, 0, 0));
        smp(pk(0, 40, 0, 0));
        smp(pk(0, 40, 0, 0));
        smp(pk(0, 40, 0, 0));
        chk("t1_early", 64'(evt_if.evt_valid), 64'd0);
        smp(pk(0, 0, 0, 0));
        chk_evt("t1", 1, 200, 2);
        idle(2);
        chk_evt("t1_hold", 1, 200, 2);
        ack1();
        chk("t1_bubble", 64'(evt_if.evt_valid), 64'd0);

        // Hysteresis band holds the quiet count (timer 8..12).
        smp(pk(120, 0, 0, 0));
        smp(pk(40, 0, 0, 0));
        smp(pk(70, 0, 0, 0));
        smp(pk(40, 0, 0, 0));
        idle(1);
        chk("t2_band_open", 64'(evt_if.evt_valid), 64'd0);
        smp(pk(40, 0, 0, 0));
        idle(1);
        chk_evt("t2a", 0, 120, 8);
        ack1();

        // A new crossing resets the quiet count and raises the peak (timer 13..19).
        smp(pk(120, 0, 0, 0));
        smp(pk(40, 0, 0, 0));
        smp(pk(40, 0, 0, 0));
        smp(pk(200, 0, 0, 0));
        smp(pk(40, 0, 0, 0));
        smp(pk(40, 0, 0, 0));
        idle(1);
        chk("t2_reset_q", 64'(evt_if.evt_valid), 64'd0);
        smp(pk(40, 0, 0, 0));
        idle(1);
        chk_evt("t2b", 0, 200, 16);
        ack1();

        // Make ch2 the last grant (timer 20..23).
        smp(pk(0, 0, 150, 0));
        repeat (3) smp(pk(0, 0, 40, 0));
        idle(1);
        chk_evt("t3_pre", 2, 150, 20);
        ack1();

        // ch0, ch2, ch3 close together (timer 24..27): expect 3, 0, 2.
        smp(pk(110, 0, 130, 140));
        repeat (3) smp(pk(40, 40, 40, 40));
        idle(1);
        chk_evt("t3_first", 3, 140, 24);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("t3_stable_ch",   64'(evt_if.evt_ch),   64'd3);
            chk("t3_stable_peak", 64'(evt_if.evt_peak), 64'd140);
        end
        ack1();
        chk("t3_bubble", 64'(evt_if.evt_valid), 64'd0);
        idle(1);
        chk_evt("t3_second", 0, 110, 24);
        evt_if.evt_ack = 1'b1;
        @(posedge clk);
        #1;
        chk("t3_bubble2", 64'(evt_if.evt_valid), 64'd0);
        @(posedge clk);
        #1;
        evt_if.evt_ack = 1'b0;
        chk_evt("t3_third", 2, 130, 24);
        ack1();

        // Overflow on ch1 (timer 28..32).
        smp(pk(0, 150, 0, 0));
        repeat (3) smp(pk(0, 40, 0, 0));
        idle(1);
        chk_evt("t4_evt", 1, 150, 28);
        smp(pk(0, 150, 0, 0));
        chk("t4_ovf_set", 64'(ovf), 64'd2);
        chk_evt("t4_held", 1, 150, 28);
        idle(2);
        ack1();
        idle(2);
        chk("t4_no_second", 64'(evt_if.evt_valid), 64'd0);
        chk("t4_sticky", 64'(ovf), 64'd2);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("t4_clr", 64'(ovf), 64'd0);

        // Clear and a new drop in the same cycle (timer 33..37).
        smp(pk(0, 150, 0, 0));
        repeat (3) smp(pk(0, 40, 0, 0));
        idle(1);
        chk_evt("t4_evt2", 1, 150, 33);
        ovf_clr = 1'b1;
        smp(pk(0, 150, 0, 0));
        ovf_clr = 1'b0;
        chk("t4_set_wins", 64'(ovf), 64'd2);
        ack1();
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;

        // Reset while ch0 is in a window and ch3's event is mid-handshake.
        smp(pk(200, 0, 0, 180));
        repeat (3) smp(pk(70, 0, 0, 40));
        idle(1);
        chk_evt("t5_pre", 3, 180, 38);
        smp(pk(70, 0, 0, 200));
        chk("t5_pre_ovf", 64'(ovf), 64'd8);
        evt_if.evt_ack = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("t5_async_vld",  64'(evt_if.evt_valid), 64'd0);
        chk("t5_async_ch",   64'(evt_if.evt_ch),    64'd0);
        chk("t5_async_peak", 64'(evt_if.evt_peak),  64'd0);
        chk("t5_async_time", 64'(evt_if.evt_time),  64'd0);
        chk("t5_async_ovf",  64'(ovf),              64'd0);
        @(posedge clk);
        #1;
        rst            = 1'b1;
        evt_if.evt_ack = 1'b0;
        idle(2);
        chk("t5_discarded", 64'(evt_if.evt_valid), 64'd0);
        smp(pk(0, 0, 160, 0));
        repeat (3) smp(pk(0, 0, 40, 0));
        idle(1);
        chk_evt("t5_fresh", 2, 160, 0);
        ack1();

        // Long window on ch2 (timer 4..26).
        repeat (20) smp(pk(0, 0, 300, 0));
        idle(1);
`ifdef THRESHOLD_MAXWIN_EN
        chk("t6_long", 64'(evt_if.evt_valid), 64'd1);
`else
        chk("t6_long", 64'(evt_if.evt_valid), 64'd0);
`endif
        repeat (3) smp(pk(0, 0, 40, 0));
        idle(1);
        chk_evt("t6_evt", 2, 300, 4);
        ack1();

        // HOLD of 0 behaves as 1 (timer 27..28).
        hold_cnt = 8'd0;
        smp(pk(0, 0, 0, 150));
        smp(pk(0, 0, 0, 40));
        idle(1);
        chk_evt("t7_hold0", 3, 150, 27);
        ack1();
        idle(2);
        chk("end_idle", 64'(evt_if.evt_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
